// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage data memory controller: RV32I
// load/store FUNC3 encodings, controller state encoding and small decode
// helpers used by both the alignment datapath and the controller.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

  // Stores only exist as SB/SH/SW; loads add the unsigned byte/half forms.
  function automatic logic func3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the data memory controller. The request side
// (current pipeline inputs) yields byte enables, replicated store data and
// the legality/alignment verdict; the load side (registered access info)
// extracts and extends the addressed bytes from the returned memory word.
module load_store_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  req_func3_i,
  input  logic        req_is_store_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        access_ok_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_shifted;

  assign access_ok_o   = func3_legal(req_func3_i, req_is_store_i)
                       && addr_aligned(req_func3_i, req_off_i);
  assign rdata_shifted = rdata_i >> {ld_off_i, 3'b000};

  // Store lanes: enables follow size and offset, data is replicated so the
  // addressed lane always carries the low bytes of rs2.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    byte_en_o = 4'b1111;
    wdata_o   = req_wdata_i;
    if (req_is_store_i) begin
      case (req_func3_i)
        F3_B: begin
          byte_en_o = 4'b0001 << req_off_i;
          wdata_o   = {4{req_wdata_i[7:0]}};
        end
        F3_H: begin
          byte_en_o = 4'b0011 << req_off_i;
          wdata_o   = {2{req_wdata_i[15:0]}};
        end
        F3_W:    byte_en_o = 4'b1111;
        default: byte_en_o = 4'b0000;
      endcase
    end
  end

  // Load result: sign- or zero-extend the addressed byte/halfword.
  always_comb begin
    rdata_o = '0;
    case (ld_func3_i)
      F3_B:    rdata_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_BU:   rdata_o = {24'h0, rdata_shifted[7:0]};
      F3_H:    rdata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_HU:   rdata_o = {16'h0, rdata_shifted[15:0]};
      F3_W:    rdata_o = rdata_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller. Accepts one load or store from the
// pipeline, runs it over a REQ/ACK handshake to a multi-cycle word memory,
// stalls the pipeline with BUSYWAIT until the access completes, and reports
// illegal requests (FAULT) and unresponsive memory (TIMEOUT) as pulses.
module data_mem_controller
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        FAULT,
  output logic        TIMEOUT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [TIMER_WIDTH-1:0] timer_d;
  logic [31:0]            read_data_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            mem_wdata_q;
  logic [3:0]             mem_byte_en_q;
  logic                   fault_q;
  logic                   timeout_q;
  logic [2:0]             ld_func3_q;
  logic [1:0]             ld_off_q;

  logic        req_any;
  logic        req_valid;
  logic        access_ok;
  logic [3:0]  lane_byte_en;
  logic [31:0] lane_wdata;
  logic [31:0] load_result;

  load_store_align u_align (
    .req_func3_i    (FUNC3),
    .req_is_store_i (MEM_WRITE),
    .req_off_i      (ADDRESS[1:0]),
    .req_wdata_i    (WRITE_DATA),
    .byte_en_o      (lane_byte_en),
    .wdata_o        (lane_wdata),
    .access_ok_o    (access_ok),
    .ld_func3_i     (ld_func3_q),
    .ld_off_i       (ld_off_q),
    .rdata_i        (MEM_RDATA),
    .rdata_o        (load_result)
  );

  assign req_any   = MEM_READ | MEM_WRITE;
  assign req_valid = (MEM_READ ^ MEM_WRITE) & access_ok;
  assign timer_d   = timer_q + 1'b1;

  // Stall immediately on an accepted request and throughout the handshake;
  // DONE releases the pipeline for exactly one cycle.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      BUSYWAIT = (state_q == ST_WAIT_ACK) || ((state_q == ST_IDLE) && req_valid);
    end
  end

  // Controller FSM with timeout counter and registered memory-side outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: every register is reset here so an access aborted mid-flight
      // leaves no request on the bus and no stale state behind.
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      read_data_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      fault_q       <= 1'b0;
      timeout_q     <= 1'b0;
      ld_func3_q    <= '0;
      ld_off_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block sampling the pre-edge values.
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q       <= ST_WAIT_ACK;
            timer_q       <= '0;
            mem_req_q     <= 1'b1;
            mem_we_q      <= MEM_WRITE;
            mem_addr_q    <= {ADDRESS[31:2], 2'b00};
            mem_wdata_q   <= lane_wdata;
            mem_byte_en_q <= lane_byte_en;
            ld_func3_q    <= FUNC3;
            ld_off_q      <= ADDRESS[1:0];
          end else if (req_any) begin
            fault_q <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (MEM_ACK) begin
            if (!mem_we_q) begin
              read_data_q <= load_result;
            end
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (timer_q == TIMER_LIMIT) begin
            timeout_q   <= 1'b1;
            read_data_q <= '0;
            mem_req_q   <= 1'b0;
            state_q     <= ST_DONE;
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign READ_DATA   = read_data_q;
  assign FAULT       = fault_q;
  assign TIMEOUT     = timeout_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign MEM_BYTE_EN = mem_byte_en_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: stores, loads of every width,
// illegal requests, timeout, ack-at-limit and reset during an access.
module tb_data_mem_controller;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        FAULT;
  logic        TIMEOUT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] RWORD = 32'h80F0_7F81;

  data_mem_controller #(
    .TIMEOUT_CYCLES (4),
    .TIMER_WIDTH    (8)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_READ    (MEM_READ),
    .MEM_WRITE   (MEM_WRITE),
    .FUNC3       (FUNC3),
    .ADDRESS     (ADDRESS),
    .WRITE_DATA  (WRITE_DATA),
    .READ_DATA   (READ_DATA),
    .BUSYWAIT    (BUSYWAIT),
    .FAULT       (FAULT),
    .TIMEOUT     (TIMEOUT),
    .MEM_REQ     (MEM_REQ),
    .MEM_WE      (MEM_WE),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_BYTE_EN (MEM_BYTE_EN),
    .MEM_RDATA   (MEM_RDATA),
    .MEM_ACK     (MEM_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  // Store with ACK on the first WAIT_ACK cycle.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input string tag);
    MEM_WRITE = 1'b1; FUNC3 = f3; ADDRESS = addr; WRITE_DATA = wd;
    #1 check({tag, "_busy_req"}, 32'(BUSYWAIT), 32'd1);
    step();
    clear_req();
    check({tag, "_req"}, 32'(MEM_REQ), 32'd1);
    check({tag, "_we"}, 32'(MEM_WE), 32'd1);
    check({tag, "_be"}, 32'(MEM_BYTE_EN), 32'(exp_be));
    check({tag, "_wdata"}, MEM_WDATA, exp_wd);
    check({tag, "_addr"}, MEM_ADDR, {addr[31:2], 2'b00});
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    check({tag, "_done_busy"}, 32'(BUSYWAIT), 32'd0);
    step();
  endtask

  // Load with ACK on the first WAIT_ACK cycle; result checked in DONE and IDLE.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp,
                         input string tag);
    MEM_READ = 1'b1; FUNC3 = f3; ADDRESS = addr;
    #1 check({tag, "_busy_req"}, 32'(BUSYWAIT), 32'd1);
    step();
    clear_req();
    check({tag, "_req_rd"}, {MEM_REQ, MEM_WE, MEM_BYTE_EN}, 32'b1_0_1111);
    MEM_ACK = 1'b1; MEM_RDATA = rdata;
    step();
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    check({tag, "_data"}, READ_DATA, exp);
    check({tag, "_done_busy"}, 32'(BUSYWAIT), 32'd0);
    step();
    check({tag, "_hold"}, READ_DATA, exp);
  endtask

  // Invalid request: no stall, FAULT pulse next cycle, no memory request.
  task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input string tag);
    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = addr;
    #1 check({tag, "_busy"}, 32'(BUSYWAIT), 32'd0);
    step();
    clear_req();
    check({tag, "_fault"}, 32'(FAULT), 32'd1);
    check({tag, "_req"}, 32'(MEM_REQ), 32'd0);
    step();
    check({tag, "_fault_end"}, 32'(FAULT), 32'd0);
  endtask

  initial begin
    int busy;
    int n;
    RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b1; FUNC3 = 3'b010;
    ADDRESS = 32'h10; WRITE_DATA = '0; MEM_RDATA = '0; MEM_ACK = 1'b0;
    step();
    step();
    // A valid-looking request during reset must not stall.
    check("rst_busy", 32'(BUSYWAIT), 32'd0);
    check("rst_outs", {MEM_REQ, MEM_WE, FAULT, TIMEOUT, MEM_BYTE_EN}, 32'd0);
    check("rst_rdata", READ_DATA, 32'd0);
    check("rst_addr", MEM_ADDR | MEM_WDATA, 32'd0);
    MEM_WRITE = 1'b0;
    RESET = 1'b0;
    step();

    // SW, ACK on the third WAIT_ACK cycle: four stall cycles, then DONE.
    busy = 0;
    MEM_WRITE = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0000_0010; WRITE_DATA = 32'hDEAD_BEEF;
    #1 busy += int'(BUSYWAIT);
    check("sw_req_idle", 32'(MEM_REQ), 32'd0);
    step();
    busy += int'(BUSYWAIT);
    check("sw_req", {MEM_REQ, MEM_WE, MEM_BYTE_EN}, 32'b1_1_1111);
    check("sw_addr", MEM_ADDR, 32'h0000_0010);
    check("sw_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    step();
    busy += int'(BUSYWAIT);
    step();
    busy += int'(BUSYWAIT);
    check("sw_req_w2", 32'(MEM_REQ), 32'd1);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    check("sw_busy_cycles", 32'(busy), 32'd4);
    check("sw_done", {BUSYWAIT, MEM_REQ, FAULT, TIMEOUT}, 32'd0);
    check("sw_hold_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    // Requests in DONE are ignored, even invalid ones.
    MEM_READ = 1'b1; MEM_WRITE = 1'b1;
    step();
    check("done_ignore_fault", 32'(FAULT), 32'd0);
    clear_req();
    step();

    do_store(3'b000, 32'h0000_0013, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "sb_off3");
    do_store(3'b001, 32'h0000_0102, 32'h1234_5678, 4'b1100, 32'h5678_5678, "sh_off2");
    do_store(3'b000, 32'h0000_0201, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C, "sb_off1");

    do_load(3'b000, 32'h0000_0040, RWORD, 32'hFFFF_FF81, "lb_off0");
    do_load(3'b100, 32'h0000_0043, RWORD, 32'h0000_0080, "lbu_off3");
    do_load(3'b001, 32'h0000_0042, RWORD, 32'hFFFF_80F0, "lh_off2");
    do_load(3'b101, 32'h0000_0040, RWORD, 32'h0000_7F81, "lhu_off0");
    do_load(3'b000, 32'h0000_0041, RWORD, 32'h0000_007F, "lb_off1");
    do_load(3'b010, 32'h0000_0044, RWORD, 32'h80F0_7F81, "lw_off0");

    do_fault(1'b1, 1'b0, 3'b010, 32'h0000_0002, "lw_misaligned");
    do_fault(1'b1, 1'b1, 3'b010, 32'h0000_0010, "rd_and_wr");
    do_fault(1'b1, 1'b0, 3'b001, 32'h0000_0001, "lh_misaligned");
    do_fault(1'b0, 1'b1, 3'b100, 32'h0000_0010, "store_bad_f3");
    do_fault(1'b1, 1'b0, 3'b011, 32'h0000_0010, "load_bad_f3");
    check("fault_keeps_rdata", READ_DATA, 32'h80F0_7F81);

    // No ACK: four WAIT_ACK cycles, then TIMEOUT pulse with READ_DATA cleared.
    MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0000_0020;
    step();
    clear_req();
    n = 0;
    while (MEM_REQ && n < 20) begin
      step();
      n++;
    end
    check("to_wait_cycles", 32'(n), 32'd4);
    check("to_pulse", {TIMEOUT, BUSYWAIT, MEM_REQ}, 32'b100);
    check("to_rdata", READ_DATA, 32'd0);
    step();
    check("to_pulse_end", 32'(TIMEOUT), 32'd0);

    // ACK on the last allowed cycle: ack wins, no TIMEOUT.
    MEM_READ = 1'b1; FUNC3 = 3'b001; ADDRESS = 32'h0000_0022;
    step();
    clear_req();
    step();
    step();
    step();
    check("lim_still_req", 32'(MEM_REQ), 32'd1);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
    step();
    MEM_ACK = 1'b0;
    check("lim_no_timeout", 32'(TIMEOUT), 32'd0);
    check("lim_rdata", READ_DATA, 32'h0000_1234);
    step();

    // Reset during WAIT_ACK: request and stall drop at once, late ACK ignored.
    MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0000_0030;
    step();
    clear_req();
    check("mid_req", 32'(MEM_REQ), 32'd1);
    #2 RESET = 1'b1;
    #1 check("mid_rst_drop", {MEM_REQ, BUSYWAIT}, 32'd0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE_F00D;
    step();
    RESET = 1'b0;
    step();
    check("late_ack_rdata", READ_DATA, 32'd0);
    check("late_ack_idle", {MEM_REQ, BUSYWAIT, TIMEOUT, FAULT}, 32'd0);
    step();
    MEM_ACK = 1'b0;
    check("late_ack_still", {MEM_REQ, BUSYWAIT}, 32'd0);

    // Controller is usable again after the abort.
    do_load(3'b100, 32'h0000_0052, RWORD, 32'h0000_00F0, "post_rst_lbu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
Sequences data-memory accesses in the MEM stage of the RISC-V pipeline. It takes the control unit's MEM_READ/MEM_WRITE and FUNC3 together with the ALU address and rs2 data. It drives a multi-cycle, word-wide data memory through a REQ/ACK handshake and holds BUSYWAIT high to stall the pipeline until the access completes. It also generates byte enables for SB/SH/SW, extends LB/LH/LBU/LHU/LW results, and flags misaligned or illegal accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT_ACK cycles before abort (1..255)
TIMER_WIDTH, 8, width of the timeout counter

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
MEM_READ  in  1  load request from control unit
MEM_WRITE  in  1  store request from control unit
FUNC3  in  3  access size/sign (RV32I load/store encoding)
ADDRESS  in  32  byte address from ALU
WRITE_DATA  in  32  rs2 store data
READ_DATA  out  32  extended load result, valid in DONE
BUSYWAIT  out  1  pipeline stall request
FAULT  out  1  1-cycle pulse: misaligned, illegal FUNC3, or both MEM_READ and MEM_WRITE
TIMEOUT  out  1  1-cycle pulse: memory did not ack in time
MEM_REQ  out  1  request to memory
MEM_WE  out  1  1 = write, 0 = read
MEM_ADDR  out  32  word address {ADDRESS[31:2],2'b00}
MEM_WDATA  out  32  lane-replicated store data
MEM_BYTE_EN  out  4  byte-lane enables
MEM_RDATA  in  32  memory read word
MEM_ACK  in  1  memory completion, sampled only in WAIT_ACK

Behaviour:
- Reset (asynchronous): state=IDLE, timer=0, READ_DATA=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_BYTE_EN=0, FAULT=0, TIMEOUT=0. BUSYWAIT is 0 while RESET is high.
- States are IDLE, WAIT_ACK and DONE.
- A request is valid when exactly one of MEM_READ/MEM_WRITE is set, FUNC3 is legal and the address is aligned.
  - Legal load FUNC3: 000, 001, 010, 100, 101.
  - Legal store FUNC3: 000, 001, 010.
  - Alignment: halfword needs ADDRESS[0]=0; word needs ADDRESS[1:0]=00.
- IDLE:
  - Valid request: BUSYWAIT=1 combinationally in the same cycle. Register address, size, sign, data and direction. Next state WAIT_ACK, timer=0.
  - Invalid request: FAULT pulses for the next cycle. No memory access, BUSYWAIT=0, stay in IDLE.
  - No request: idle, all outputs hold.
- WAIT_ACK:
  - MEM_REQ=1 and BUSYWAIT=1. MEM_WE, MEM_ADDR, MEM_WDATA and MEM_BYTE_EN stay stable from registered values.
  - MEM_ACK=1: on a read, latch the formatted MEM_RDATA into READ_DATA. Go to DONE and drop MEM_REQ.
  - Otherwise timer increments. When timer==TIMEOUT_CYCLES-1 without ack: TIMEOUT pulses, READ_DATA=0, go to DONE.
  - If ACK and the timeout limit coincide, the ack wins and TIMEOUT is not asserted.
- DONE:
  - BUSYWAIT=0 for exactly one cycle so the pipeline advances at the end of this cycle. Requests are ignored. Next state IDLE.
  - READ_DATA holds until the next completed load.
- Minimum stall is 2 cycles: request cycle plus one WAIT_ACK cycle, with ACK on the first WAIT_ACK cycle.
- Byte enables, with off = ADDRESS[1:0]:
  - SB: 4'b0001<<off, MEM_WDATA={4{WRITE_DATA[7:0]}}.
  - SH: 4'b0011<<off, MEM_WDATA={2{WRITE_DATA[15:0]}}.
  - SW: 4'b1111.
  - Reads use 4'b1111.
- Load format: shift MEM_RDATA right by 8*off.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESET asserted mid-access: abort immediately with MEM_REQ low. An ACK arriving after reset is ignored.

Decomposition:
- Shared package rv_mem_pkg: FUNC3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and state encodings.
- One sub-module, load_store_align: purely combinational. Produces byte enables, store lane replication, load extraction/extension and the misalign/illegal check.
- The controller FSM, timer and registers stay in the top module.

Test Plan:
- SW at 0x0000_0010 with WRITE_DATA 0xDEADBEEF, ACK on the 3rd WAIT_ACK cycle -> MEM_BYTE_EN=1111, MEM_WE=1, BUSYWAIT high for 4 cycles, then DONE for 1 cycle.
- SB at 0x...13 with WRITE_DATA 0x000000A5 -> MEM_BYTE_EN=1000, MEM_WDATA=0xA5A5A5A5, MEM_ADDR=0x...10.
- MEM_RDATA=0x80F0_7F81, immediate ACK -> LB off=0 gives 0xFFFFFF81; LBU off=3 gives 0x00000080; LH off=2 gives 0xFFFF80F0; LHU off=0 gives 0x00007F81.
- LW at 0x...02, and also MEM_READ=MEM_WRITE=1 -> FAULT pulse, MEM_REQ stays 0, BUSYWAIT=0.
- TIMEOUT_CYCLES=4 with no ACK -> TIMEOUT pulses after 4 WAIT_ACK cycles, READ_DATA=0, then DONE.
- RESET raised during WAIT_ACK -> MEM_REQ and BUSYWAIT drop the same cycle, state=IDLE, and a late ACK causes no change.
